calc_entry_sequencer: RTL

- Upstream operand/opcode entry stage for the 3-bit calculator.
- Collects A, B and an opcode from a strobed key-entry interface, then drives them as registered operands to the arithmetic units (add/sub/mul/remainder mux).
- After a settle window it captures the selected unit's result and SF/ZF/DZF flags, and holds them under a valid/ack handshake.
- Keeps a saturating count of divide-by-zero results.

---
 rtl/calc_entry_sequencer.sv | 118 +++++++++++
 1 files changed

// File: rtl/calc_entry_sequencer.sv
// calc_entry_sequencer: collects A, B and opcode from key strobes, drives the ALU,
// captures its result after a settle window and holds it under a valid/ack handshake.
module calc_entry_sequencer #(
    parameter int WIDTH       = 3,
    parameter int EXEC_CYCLES = 1,
    parameter int CNT_W       = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] key_data,
    input  logic             key_strobe,
    input  logic             key_clear,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [1:0]       alu_op,
    input  logic [WIDTH-1:0] alu_r,
    input  logic             alu_sf,
    input  logic             alu_zf,
    input  logic             alu_dzf,
    output logic [WIDTH-1:0] res,
    output logic             res_sf,
    output logic             res_zf,
    output logic             res_dzf,
    output logic             res_valid,
    input  logic             res_ack,
    output logic             busy,
    output logic [CNT_W-1:0] dz_count
);
    typedef enum logic [2:0] {IDLE, GOT_A, GOT_B, EXEC, DONE} state_t;
    localparam logic [3:0] LAST = 4'(EXEC_CYCLES - 1);
    state_t           state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d;
    logic [1:0]       op_q, op_d;
    logic             sf_q, sf_d, zf_q, zf_d, dzf_q, dzf_d, valid_q, valid_d;
    logic [CNT_W-1:0] dz_q, dz_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= '0;
            res_q   <= '0;
            sf_q    <= 1'b0;
            zf_q    <= 1'b0;
            dzf_q   <= 1'b0;
            valid_q <= 1'b0;
            dz_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            res_q   <= res_d;
            sf_q    <= sf_d;
            zf_q    <= zf_d;
            dzf_q   <= dzf_d;
            valid_q <= valid_d;
            dz_q    <= dz_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        res_d   = res_q;
        sf_d    = sf_q;
        zf_d    = zf_q;
        dzf_d   = dzf_q;
        valid_d = valid_q;
        dz_d    = dz_q;
        // An abort cannot interrupt a running execution; it only cancels entry or a held result
        if (key_clear && state_q != EXEC) begin
            state_d = IDLE;
            a_d     = '0;
            b_d     = '0;
            op_d    = '0;
            valid_d = 1'b0;
        end else begin
            case (state_q)
                IDLE:  if (key_strobe) begin a_d = key_data; state_d = GOT_A; end
                GOT_A: if (key_strobe) begin b_d = key_data; state_d = GOT_B; end
                GOT_B: if (key_strobe) begin op_d = key_data[1:0]; cnt_d = '0; state_d = EXEC; end
                EXEC: begin
                    cnt_d = cnt_q + 4'd1;
                    if (cnt_q == LAST) begin
                        res_d   = alu_r;
                        sf_d    = alu_sf;
                        zf_d    = alu_zf;
                        dzf_d   = alu_dzf;
                        valid_d = 1'b1;
                        dz_d    = (alu_dzf && !(&dz_q)) ? dz_q + CNT_W'(1) : dz_q;
                        state_d = DONE;
                    end
                end
                DONE:  if (res_ack) begin valid_d = 1'b0; state_d = IDLE; end
                default: state_d = IDLE;
            endcase
        end
    end

    assign alu_a     = a_q;
    assign alu_b     = b_q;
    assign alu_op    = op_q;
    assign res       = res_q;
    assign res_sf    = sf_q;
    assign res_zf    = zf_q;
    assign res_dzf   = dzf_q;
    assign res_valid = valid_q;
    assign dz_count  = dz_q;
    assign busy      = (state_q == EXEC) || (state_q == DONE);
endmodule
